// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - digit-serial packed BCD adder, one digit per clock
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  begin an addition (sampled only while ready=1)
//   a, b   packed BCD operands, digit 0 in [3:0]
//   cin    carry into digit 0
//   ready  idle, will accept start
//   sum    packed BCD result, held between operations
//   cout   decimal carry out of the top digit
//   done   one-cycle result-valid pulse
//   err    a captured operand digit was above 9
module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  ready,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  done,
   output logic                  err
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t              state, state_nx;
   logic [4*DIGITS-1:0] a_r, b_r, acc, acc_nx;
   logic [IW-1:0]       idx;
   logic                carry, carry_nx;
   logic [5:0]          t, t_adj;
   logic [3:0]          dig;
   logic                last;
   logic                bad;

   // Operand registers shift right each cycle so the active digit is always
   // in the low nibble; results enter at the top of acc and shift down, so
   // after DIGITS steps digit 0 sits in acc[3:0].
   always_comb begin
      t        = {2'b00, a_r[3:0]} + {2'b00, b_r[3:0]} + {5'b00000, carry};
      t_adj    = t + 6'd6;
      dig      = t[3:0];
      carry_nx = 1'b0;
      if (t > 6'd9) begin
         dig      = t_adj[3:0];
         carry_nx = 1'b1;
      end
      acc_nx                    = acc >> 4;
      acc_nx[4*DIGITS-1 -: 4]   = dig;
      last                      = (idx == IW'(DIGITS - 1));
   end

   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_nx = ADD;
            end
         end
         ADD: begin
            if (last) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         idx   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_r   <= a;
                  b_r   <= b;
                  acc   <= '0;
                  idx   <= '0;
                  carry <= cin;
                  err   <= bad;
               end
            end
            ADD: begin
               a_r   <= a_r >> 4;
               b_r   <= b_r >> 4;
               acc   <= acc_nx;
               carry <= carry_nx;
               if (last) begin
                  sum  <= acc_nx;
                  cout <= carry_nx;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb/tb_bcd_serial_adder.sv - randomized self-checking bench for bcd_serial_adder
module tb_bcd_serial_adder;

   localparam int D = 4;
   localparam int W = 4 * D;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         done;
   logic         err;

   int checks;
   int errors;

   bcd_serial_adder #(.DIGITS(D)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .sum   (sum),
      .cout  (cout),
      .done  (done),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit any_bad(input logic [W-1:0] ma, input logic [W-1:0] mb);
      bit r = 1'b0;
      for (int i = 0; i < D; i++) begin
         if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) r = 1'b1;
      end
      return r;
   endfunction

   // Returns {cout, sum}. Valid operands use plain decimal arithmetic;
   // operands with non-decimal nibbles fall back to the per-digit rule.
   function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
      logic [W:0] r = '0;
      longint va = 0;
      longint vb = 0;
      longint p = 1;
      longint tot;
      int t;
      int cy;
      if (!any_bad(ma, mb)) begin
         for (int i = D - 1; i >= 0; i--) begin
            va = va * 10 + longint'(ma[4*i +: 4]);
            vb = vb * 10 + longint'(mb[4*i +: 4]);
            p  = p * 10;
         end
         tot  = va + vb + longint'(mc);
         r[W] = (tot >= p);
         tot  = tot % p;
         for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(tot % 10);
            tot = tot / 10;
         end
      end else begin
         cy = int'(mc);
         for (int i = 0; i < D; i++) begin
            t = int'(ma[4*i +: 4]) + int'(mb[4*i +: 4]) + cy;
            if (t > 9) begin
               r[4*i +: 4] = 4'((t + 6) % 16);
               cy = 1;
            end else begin
               r[4*i +: 4] = 4'(t);
               cy = 0;
            end
         end
         r[W] = cy[0];
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_operand(input bit allow_bad);
      logic [W-1:0] v;
      for (int i = 0; i < D; i++) begin
         v[4*i +: 4] = allow_bad ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      end
      return v;
   endfunction

   // Called #1 after an edge with the DUT idle. scramble drives start and
   // fresh operands on the two cycles after acceptance.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input bit scramble);
      logic [W:0] exp;
      bit         exp_err;
      int         cnt;
      bit         seen;
      exp     = model(ta, tb_, tc);
      exp_err = any_bad(ta, tb_);
      check("ready_idle", ready, 1);
      a = ta;
      b = tb_;
      cin = tc;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < D + 5) begin
         if (scramble && cnt < 2) begin
            start = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cnt++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check("done_seen", seen, 1);
      check("latency", cnt, D);
      check("sum", sum, exp[W-1:0]);
      check("cout", cout, exp[W]);
      check("err", err, exp_err);
      check("ready_in_done", ready, 0);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("ready_after", ready, 1);
      check("sum_hold", sum, exp[W-1:0]);
   endtask

   task automatic back_to_back(input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1,
                               input logic [W-1:0] a2, input logic [W-1:0] b2, input logic c2);
      logic [W:0] e1;
      logic [W:0] e2;
      int         cnt;
      e1 = model(a1, b1, c1);
      e2 = model(a2, b2, c2);
      a = a1;
      b = b1;
      cin = c1;
      start = 1'b1;
      @(posedge clk); #1;
      a = a2;
      b = b2;
      cin = c2;
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!done && cnt < D + 5);
      check("b2b_lat1", cnt, D);
      check("b2b_sum1", {cout, sum}, e1);
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (!done && cnt < 2 * D + 8);
      start = 1'b0;
      check("b2b_gap", cnt, D + 2);
      check("b2b_sum2", {cout, sum}, e2);
      check("b2b_err2", err, any_bad(a2, b2));
      @(posedge clk); #1;
      check("b2b_ready", ready, 1);
   endtask

   initial begin
      int dcnt;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_err", err, 0);
      rst = 1'b0;

      run_op(16'h0044, 16'h0044, 1'b0, 1'b0);
      check("d0044_sum", sum, 16'h0088);
      run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
      check("d9999_sum", {cout, sum}, 17'h10000);
      run_op(16'h0006, 16'h0006, 1'b1, 1'b0);
      check("d0006_sum", {cout, sum}, 17'h00013);
      run_op(16'h000A, 16'h0001, 1'b0, 1'b0);
      check("d000a_sum", {err, cout, sum}, 18'h20011);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      check("dffff_sum", {err, cout, sum}, 18'h35555);
      run_op(16'h1234, 16'h8765, 1'b1, 1'b1);
      check("scramble_sum", {cout, sum}, 17'h10000);

      for (int n = 0; n < 24; n++) begin
         bit allow_bad;
         allow_bad = ($urandom_range(0, 7) == 0);
         run_op(rand_operand(allow_bad), rand_operand(allow_bad), 1'($urandom), 1'b1);
      end

      back_to_back(16'h0123, 16'h0456, 1'b0, 16'h5000, 16'h5999, 1'b1);
      back_to_back(rand_operand(1'b0), rand_operand(1'b0), 1'b1, rand_operand(1'b0), rand_operand(1'b0), 1'b0);

      // Leave non-zero result state behind, then reset in the second ADD cycle
      // with start asserted on the reset edge.
      run_op(16'h000A, 16'h0009, 1'b1, 1'b0);
      a = 16'h0555;
      b = 16'h0555;
      cin = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
      check("abort_ready", ready, 1);
      check("abort_sum", sum, 0);
      check("abort_cout", cout, 0);
      check("abort_err", err, 0);
      dcnt = 0;
      for (int i = 0; i < D + 4; i++) begin
         if (done) dcnt++;
         @(posedge clk); #1;
      end
      check("abort_no_done", dcnt, 0);
      check("abort_idle", ready, 1);

      run_op(16'h0999, 16'h0001, 1'b0, 1'b0);
      check("post_abort_sum", {cout, sum}, 17'h01000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
